// File: rtl/serial_tx_port_fifo_pkg.sv
// Shared definitions for the buffered serial transmit port:
// FSM encoding, line levels and a width helper.
package serial_tx_port_fifo_pkg;

   typedef enum logic [1:0] {
      TxIdle  = 2'd0,
      TxStart = 2'd1,
      TxSend  = 2'd2,
      TxDone  = 2'd3
   } tx_state_e;

   localparam logic START_BIT  = 1'b1;
   localparam logic IDLE_LEVEL = 1'b0;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_tx_port_fifo_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and a live occupancy count.
// Read data is the current head, valid whenever empty is low.
module serial_tx_port_fifo_sync_fifo
   import serial_tx_port_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PtrW   = cnt_width(DEPTH);
   localparam int unsigned CountW = $clog2(DEPTH+1);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CountW-1:0] count_q;
   logic              push_en, pop_en;

   assign full    = (count_q == CountW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally; count alone separates full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop_en) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CountW'(1);
            2'b01:   count_q <= count_q - CountW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/serial_tx_port_fifo.sv
// Buffered slave serial output port: queues words from the slave core and sends one
// framed word (start bit + data bits) per master request on a single line.
module serial_tx_port_fifo
   import serial_tx_port_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_WIDTH-1:0]           datain,
   input  logic                            slave_valid,
   output logic                            slave_ready,
   input  logic                            master_ready,
   output logic                            tx_data,
   output logic                            tx_busy,
   output logic                            slave_tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int unsigned CntW = cnt_width(DATA_WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  tx_data_q, tx_data_d;
   logic                  tx_busy_q, tx_busy_d;
   logic                  done_q, done_d;
   logic                  fifo_full, fifo_empty, pop;
   logic [DATA_WIDTH-1:0] head;
   logic                  out_bit;

   serial_tx_port_fifo_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (slave_valid),
      .wdata (datain),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign slave_ready = ~fifo_full;
   // Requests are only honoured from idle with data waiting; nothing is latched otherwise.
   assign pop = (state_q == TxIdle) && master_ready && !fifo_empty;

   always_comb begin
      if (MSB_FIRST) begin
         out_bit = shift_q[DATA_WIDTH-1];
         shifted = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
         out_bit = shift_q[0];
         shifted = {1'b0, shift_q[DATA_WIDTH-1:1]};
      end
   end

   // Outputs are computed for the state being entered and registered with it.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      tx_data_d = IDLE_LEVEL;
      tx_busy_d = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         TxIdle: begin
            if (pop) begin
               state_d   = TxStart;
               shift_d   = head;
               cnt_d     = '0;
               tx_data_d = START_BIT;
               tx_busy_d = 1'b1;
            end
         end
         TxStart: begin
            state_d   = TxSend;
            tx_data_d = out_bit;
            shift_d   = shifted;
            tx_busy_d = 1'b1;
         end
         TxSend: begin
            // cnt_q is the index of the bit currently on the line.
            if (cnt_q == LastCnt) begin
               state_d = TxDone;
               done_d  = 1'b1;
            end else begin
               tx_data_d = out_bit;
               shift_d   = shifted;
               cnt_d     = cnt_q + CntW'(1);
               tx_busy_d = 1'b1;
            end
         end
         TxDone: begin
            state_d = TxIdle;
         end
         default: begin
            state_d = TxIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= TxIdle;
         shift_q   <= '0;
         cnt_q     <= '0;
         tx_data_q <= IDLE_LEVEL;
         tx_busy_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_busy_q <= tx_busy_d;
         done_q    <= done_d;
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_busy       = tx_busy_q;
   assign slave_tx_done = done_q;

endmodule

// File: tb/tb_serial_tx_port_fifo.sv
// Bench for serial_tx_port_fifo: LSB-first and MSB-first instances share one stimulus
// stream and are checked every cycle against a frame-timeline model.
module tb_serial_tx_port_fifo;

   localparam int unsigned W  = 12;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          reset, sv, mr;
   logic [W-1:0]  din;
   logic          rdy_l, tx_l, busy_l, done_l;
   logic          rdy_m, tx_m, busy_m, done_m;
   logic [CW-1:0] cnt_l, cnt_m;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   serial_tx_port_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .datain(din), .slave_valid(sv), .slave_ready(rdy_l),
      .master_ready(mr), .tx_data(tx_l), .tx_busy(busy_l), .slave_tx_done(done_l),
      .fifo_count(cnt_l)
   );

   serial_tx_port_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .datain(din), .slave_valid(sv), .slave_ready(rdy_m),
      .master_ready(mr), .tx_data(tx_m), .tx_busy(busy_m), .slave_tx_done(done_m),
      .fifo_count(cnt_m)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a word queue plus the position within the current frame.
   // pos: -1 idle, 0 start bit, 1..W data bits, W+1 done pulse.
   logic [W-1:0] mq[$];
   logic [W-1:0] cur = '0;
   int pos = -1;
   bit model_on = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         mq.delete();
         pos = -1;
         model_on = 1'b1;
      end else begin
         bit do_push;
         do_push = sv && (mq.size() < D);
         if (pos < 0 && mr && mq.size() > 0) begin
            cur = mq.pop_front();
            pos = 0;
         end else if (pos >= 0) begin
            pos = (pos == W + 1) ? -1 : pos + 1;
         end
         if (do_push) mq.push_back(din);
      end
   end

   function automatic int exp_tx(input bit msb);
      if (pos == 0) return 1;
      if (pos >= 1 && pos <= W) return int'(cur[msb ? (W - pos) : (pos - 1)]);
      return 0;
   endfunction

   always @(negedge clk) begin
      if (model_on) begin
         check("tx_data_lsb", tx_l, exp_tx(1'b0));
         check("tx_data_msb", tx_m, exp_tx(1'b1));
         check("tx_busy_lsb", busy_l, int'(pos >= 0 && pos <= W));
         check("tx_busy_msb", busy_m, int'(pos >= 0 && pos <= W));
         check("done_lsb", done_l, int'(pos == W + 1));
         check("done_msb", done_m, int'(pos == W + 1));
         check("fifo_count_lsb", cnt_l, mq.size());
         check("fifo_count_msb", cnt_m, mq.size());
         check("slave_ready", rdy_l, int'(mq.size() < D));
      end
   end

   // Inputs change on the falling edge; the following rising edge consumes them.
   task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit m);
      reset = r;
      sv    = v;
      din   = d;
      mr    = m;
      @(negedge clk);
   endtask

   initial begin
      logic [12:0] seq_l, seq_m;
      int done_cyc[$];
      int n;

      reset = 1'b1; sv = 1'b0; mr = 1'b0; din = '0;
      @(negedge clk);
      step(1, 0, '0, 0);
      step(0, 0, '0, 0);
      check("reset_tx_data", tx_l, 0);
      check("reset_busy", busy_l, 0);
      check("reset_count", cnt_l, 0);
      check("reset_ready", rdy_l, 1);

      // Single word 0xCCC, one-cycle request.
      step(0, 1, 12'hCCC, 0);
      check("ccc_count_after_push", cnt_l, 1);
      step(0, 0, '0, 1);
      check("ccc_count_after_pop", cnt_l, 0);
      seq_l = {12'b0, tx_l};
      seq_m = {12'b0, tx_m};
      for (int i = 0; i < 12; i++) begin
         step(0, 0, '0, 0);
         seq_l = {seq_l[11:0], tx_l};
         seq_m = {seq_m[11:0], tx_m};
      end
      check("ccc_frame_lsb", int'(seq_l), int'(13'b1_0011_0011_0011));
      check("ccc_frame_msb", int'(seq_m), int'(13'b1_1100_1100_1100));
      step(0, 0, '0, 0);
      check("ccc_done_at_14", done_l, 1);

      // Fill to depth, then a dropped fifth push.
      step(0, 1, 12'h111, 0);
      step(0, 1, 12'h222, 0);
      step(0, 1, 12'h333, 0);
      step(0, 1, 12'h444, 0);
      check("full_ready", rdy_l, 0);
      check("full_count", cnt_l, 4);
      step(0, 1, 12'h555, 0);
      check("drop_count", cnt_l, 4);
      step(0, 0, '0, 1);
      for (int i = 0; i < 13; i++) step(0, 0, '0, 0);
      check("after_xfer_count", cnt_l, 3);
      check("after_xfer_ready", rdy_l, 1);

      // Level request drains the remaining three words back to back.
      for (int i = 0; i < 60; i++) begin
         step(0, 0, '0, 1);
         if (done_l) done_cyc.push_back(cyc);
      end
      n = done_cyc.size();
      check("b2b_done_pulses", n, 3);
      if (n == 3) begin
         check("b2b_period_1", done_cyc[1] - done_cyc[0], 15);
         check("b2b_period_2", done_cyc[2] - done_cyc[1], 15);
      end
      step(0, 0, '0, 0);
      check("drained_tx_idle", tx_l, 0);

      // Request with nothing queued is not remembered.
      step(0, 0, '0, 1);
      check("empty_req_busy", busy_l, 0);
      step(0, 1, 12'h0F0, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, '0, 0);
         if (busy_l) n++;
      end
      check("no_autostart", n, 0);
      check("no_autostart_count", cnt_l, 1);

      // Reset while bit 5 of 0x0F0 is on the line.
      step(0, 1, 12'h123, 0);
      step(0, 0, '0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, '0, 0);
      check("bit5_value", tx_l, 1);
      check("bit5_count", cnt_l, 1);
      step(1, 0, '0, 0);
      check("abort_tx", tx_l, 0);
      check("abort_busy", busy_l, 0);
      check("abort_count", cnt_l, 0);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         step(0, 0, '0, 0);
         if (done_l || done_m) n++;
      end
      check("abort_no_done", n, 0);

      // 0xA05 on both bit orders.
      step(0, 1, 12'hA05, 0);
      step(0, 0, '0, 1);
      seq_l = {12'b0, tx_l};
      seq_m = {12'b0, tx_m};
      for (int i = 0; i < 12; i++) begin
         step(0, 0, '0, 0);
         seq_l = {seq_l[11:0], tx_l};
         seq_m = {seq_m[11:0], tx_m};
      end
      check("a05_frame_msb", int'(seq_m), int'(13'b1_1010_0000_0101));
      check("a05_frame_lsb", int'(seq_l), int'(13'b1_1010_0000_0101));
      step(0, 0, '0, 0);
      check("a05_done", done_m, 1);
      step(0, 0, '0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
